// File: rtl/cipher_kat_engine.sv
// cipher_kat_engine
//   Known-answer-test sequencer for a block-cipher core with a key/din/dout
//   strobe interface. It latches a key and a plaintext/ciphertext pair at
//   start, loads the key once, then runs ITERS encrypt/decrypt round trips.
//   Every core result is checked against the latched vector. The error count
//   saturates at all-ones.
//
//   Optional build macro CIPHER_KAT_TIMEOUT_EN adds a watchdog. The watchdog
//   aborts a run that waits too long for i_key_ok or i_dout_en.
//
// Ports
//   i_clk, i_rst             clock, synchronous active-high reset
//   i_start                  start a run (accepted in IDLE/DONE only)
//   i_kat_key/pt/ct          test vectors, latched at start
//   o_key, o_key_en          key to core, one-cycle load strobe
//   o_din, o_din_en, o_flag  block to core, one-cycle strobe, 1=encrypt
//   i_dout, i_dout_en        core result and valid
//   i_key_ok                 core key expansion complete (level)
//   o_busy, o_done, o_pass   run status (done is a level until next start)
//   o_err_cnt                mismatches in the current/last run
//   o_timeout                watchdog fired (constant 0 without the macro)
module cipher_kat_engine #(
    parameter int unsigned KEY_W = 128,
    parameter int unsigned BLK_W = 64,
    parameter int unsigned ITERS = 8,
    parameter int unsigned ERR_W = 8,
    parameter int unsigned TMO_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [KEY_W-1:0] i_kat_key,
    input  logic [BLK_W-1:0] i_kat_pt,
    input  logic [BLK_W-1:0] i_kat_ct,
    output logic [KEY_W-1:0] o_key,
    output logic             o_key_en,
    output logic [BLK_W-1:0] o_din,
    output logic             o_din_en,
    output logic             o_flag,
    input  logic [BLK_W-1:0] i_dout,
    input  logic             i_dout_en,
    input  logic             i_key_ok,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [ERR_W-1:0] o_err_cnt,
    output logic             o_timeout
);

    localparam int unsigned IT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam logic [IT_W-1:0] ITER_LAST = IT_W'(ITERS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_WKEY, S_WENC, S_WDEC, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [BLK_W-1:0] pt_q, pt_d, ct_q, ct_d, din_q, din_d;
    logic [IT_W-1:0]  iter_q, iter_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             key_en_q, key_en_d, din_en_q, din_en_d, flag_q, flag_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             err_inc;
    logic             rsp_ok;

    // A result in the same cycle as our own strobe cannot answer that
    // strobe. Ignoring it also keeps o_din_en from firing back-to-back.
    assign rsp_ok = i_dout_en && !din_en_q;

`ifdef CIPHER_KAT_TIMEOUT_EN
    localparam logic [TMO_W-1:0] TMO_LAST = ~TMO_W'(1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             timeout_q, timeout_d;
    logic             waiting, evt;

    assign waiting = (state_q == S_WKEY) || (state_q == S_WENC) || (state_q == S_WDEC);
    assign evt     = ((state_q == S_WKEY) && i_key_ok) ||
                     (((state_q == S_WENC) || (state_q == S_WDEC)) && rsp_ok);
    assign o_timeout = timeout_q;
`else
    assign o_timeout = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        key_d    = key_q;
        pt_d     = pt_q;
        ct_d     = ct_q;
        iter_d   = iter_q;
        err_d    = err_q;
        din_d    = din_q;
        flag_d   = flag_q;
        busy_d   = busy_q;
        done_d   = done_q;
        key_en_d = 1'b0;
        din_en_d = 1'b0;
        err_inc  = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    key_d    = i_kat_key;
                    pt_d     = i_kat_pt;
                    ct_d     = i_kat_ct;
                    err_d    = '0;
                    iter_d   = '0;
                    done_d   = 1'b0;
                    busy_d   = 1'b1;
                    key_en_d = 1'b1;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: state_d = S_WKEY;
            S_WKEY: begin
                if (i_key_ok) begin
                    din_en_d = 1'b1;
                    din_d    = pt_q;
                    flag_d   = 1'b1;
                    state_d  = S_WENC;
                end
            end
            S_WENC: begin
                if (rsp_ok) begin
                    err_inc  = (i_dout != ct_q);
                    din_en_d = 1'b1;
                    din_d    = ct_q;
                    flag_d   = 1'b0;
                    state_d  = S_WDEC;
                end
            end
            S_WDEC: begin
                if (rsp_ok) begin
                    err_inc = (i_dout != pt_q);
                    if (iter_q == ITER_LAST) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        // The key stays loaded, so go straight to the next encrypt.
                        iter_d   = iter_q + IT_W'(1);
                        din_en_d = 1'b1;
                        din_d    = pt_q;
                        flag_d   = 1'b1;
                        state_d  = S_WENC;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef CIPHER_KAT_TIMEOUT_EN
        tmo_d     = '0;
        timeout_d = timeout_q;
        if (((state_q == S_IDLE) || (state_q == S_DONE)) && i_start) begin
            timeout_d = 1'b0;
        end
        if (waiting && !evt) begin
            if (tmo_q == TMO_LAST) begin
                timeout_d = 1'b1;
                err_inc   = 1'b1;
                busy_d    = 1'b0;
                done_d    = 1'b1;
                state_d   = S_DONE;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end
`endif

        if (err_inc && (err_q != '1)) begin
            err_d = err_q + ERR_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            key_q    <= '0;
            pt_q     <= '0;
            ct_q     <= '0;
            din_q    <= '0;
            iter_q   <= '0;
            err_q    <= '0;
            key_en_q <= 1'b0;
            din_en_q <= 1'b0;
            flag_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            pt_q     <= pt_d;
            ct_q     <= ct_d;
            din_q    <= din_d;
            iter_q   <= iter_d;
            err_q    <= err_d;
            key_en_q <= key_en_d;
            din_en_q <= din_en_d;
            flag_q   <= flag_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

`ifdef CIPHER_KAT_TIMEOUT_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tmo_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_q     <= tmo_d;
            timeout_q <= timeout_d;
        end
    end
`endif

    assign o_key     = key_q;
    assign o_key_en  = key_en_q;
    assign o_din     = din_q;
    assign o_din_en  = din_en_q;
    assign o_flag    = flag_q;
    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_err_cnt = err_q;
    assign o_pass    = done_q && (err_q == '0);

endmodule

// File: tb/tb_cipher_kat_engine.sv
// Bench for cipher_kat_engine.
// A toy cipher core sits beside the DUT:
//   encrypt: x + K
//   decrypt: x - K
//   K = key[63:0] ^ key[127:64]
// The core has random key-expansion and result latency. Selected responses
// can be corrupted by XOR with a value from the corr table.
module tb_cipher_kat_engine;
    localparam int unsigned KEY_W = 128;
    localparam int unsigned BLK_W = 64;
    localparam int unsigned ITERS = 8;
    localparam int unsigned ERR_W = 4;
    localparam int unsigned TMO_W = 16;
    localparam int ERR_MAX = (1 << ERR_W) - 1;

    localparam logic [127:0] SPEC_KEY = 128'h915f4619be41b2516355a50110a9ce91;
    localparam logic [63:0]  SPEC_PT  = 64'h21a5dbee154b8f6d;

    logic             clk = 1'b0;
    logic             i_rst, i_start;
    logic [KEY_W-1:0] i_kat_key, o_key;
    logic [BLK_W-1:0] i_kat_pt, i_kat_ct, o_din;
    logic [BLK_W-1:0] i_dout = '0;
    logic             i_dout_en = 1'b0, i_key_ok = 1'b0;
    logic             o_key_en, o_din_en, o_flag, o_busy, o_done, o_pass, o_timeout;
    logic [ERR_W-1:0] o_err_cnt;

    cipher_kat_engine #(
        .KEY_W(KEY_W), .BLK_W(BLK_W), .ITERS(ITERS), .ERR_W(ERR_W), .TMO_W(TMO_W)
    ) dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start),
        .i_kat_key(i_kat_key), .i_kat_pt(i_kat_pt), .i_kat_ct(i_kat_ct),
        .o_key(o_key), .o_key_en(o_key_en), .o_din(o_din), .o_din_en(o_din_en),
        .o_flag(o_flag), .i_dout(i_dout), .i_dout_en(i_dout_en), .i_key_ok(i_key_ok),
        .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass), .o_err_cnt(o_err_cnt),
        .o_timeout(o_timeout)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [63:0] corr [16];
    bit          stray_en = 1'b0;

    // ---------------- toy core ----------------
    logic [63:0] kmask = '0;
    logic [63:0] res = '0;
    int          kcnt = 0, lat = 0, rsp_idx = 0;
    bit          pend = 1'b0, stray_pend = 1'b0, prev_den = 1'b0;
    int          key_en_cnt = 0, din_en_cnt = 0, viol_cnt = 0;

    always @(negedge clk) begin
        i_dout_en = 1'b0;
        if (i_rst) begin
            pend = 1'b0; kcnt = 0; i_key_ok = 1'b0; stray_pend = 1'b0; prev_den = 1'b0;
        end else begin
            if (o_din_en && prev_den) viol_cnt++;
            prev_den = o_din_en;
            if (o_key_en) begin
                key_en_cnt++;
                i_key_ok   = 1'b0;
                kmask      = o_key[63:0] ^ o_key[127:64];
                kcnt       = $urandom_range(4, 2);
                stray_pend = stray_en;
                rsp_idx    = 0;
            end else if (kcnt > 0) begin
                if (stray_pend) begin
                    i_dout_en  = 1'b1;
                    i_dout     = {$urandom, $urandom};
                    stray_pend = 1'b0;
                end
                kcnt--;
                if (kcnt == 0) i_key_ok = 1'b1;
            end
            if (o_din_en) begin
                din_en_cnt++;
                pend = 1'b1;
                lat  = $urandom_range(3, 1);
                res  = o_flag ? (o_din + kmask) : (o_din - kmask);
                if (rsp_idx < 16) res = res ^ corr[rsp_idx];
                rsp_idx++;
            end else if (pend) begin
                lat--;
                if (lat == 0) begin
                    i_dout_en = 1'b1;
                    i_dout    = res;
                    pend      = 1'b0;
                end
            end
        end
    end

    // ---------------- reference model ----------------
    // Count mismatches over ITERS round trips using the corr table.
    // Saturate the count at ERR_MAX.
    function automatic int exp_errs(input logic [127:0] key, input logic [63:0] pt,
                                    input logic [63:0] ct);
        logic [63:0] k;
        int e;
        k = key[63:0] ^ key[127:64];
        e = 0;
        for (int i = 0; i < ITERS; i++) begin
            if (((pt + k) ^ corr[2*i]) != ct) e++;
            if (((ct - k) ^ corr[2*i+1]) != pt) e++;
        end
        return (e > ERR_MAX) ? ERR_MAX : e;
    endfunction

    function automatic logic [63:0] good_ct(input logic [127:0] key, input logic [63:0] pt);
        return pt + (key[63:0] ^ key[127:64]);
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_corr();
        for (int i = 0; i < 16; i++) corr[i] = '0;
    endtask

    task automatic run_kat(input string tag, input logic [127:0] key, input logic [63:0] pt,
                           input logic [63:0] ct, input bit poke);
        int kb, db, vb, cyc, ee;
        i_kat_key = key; i_kat_pt = pt; i_kat_ct = ct;
        ee = exp_errs(key, pt, ct);
        kb = key_en_cnt; db = din_en_cnt; vb = viol_cnt;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk($sformatf("%s.busy_at_start", tag), o_busy, 1);
        chk($sformatf("%s.done_cleared", tag), o_done, 0);
        chk($sformatf("%s.err_cleared", tag), o_err_cnt, 0);
        cyc = 0;
        while (o_done !== 1'b1 && cyc < 2000) begin
            if (poke && cyc == 10) begin
                // A start while busy must be ignored. The new vectors must not leak in.
                i_start = 1'b1; i_kat_key = ~key; i_kat_pt = ~pt; i_kat_ct = ~ct;
            end else begin
                i_start = 1'b0;
            end
            tick();
            cyc++;
        end
        i_start = 1'b0;
        chk($sformatf("%s.done", tag), o_done, 1);
        chk($sformatf("%s.busy_end", tag), o_busy, 0);
        chk($sformatf("%s.err_cnt", tag), o_err_cnt, ee);
        chk($sformatf("%s.pass", tag), o_pass, (ee == 0));
        chk($sformatf("%s.key_loads", tag), key_en_cnt - kb, 1);
        chk($sformatf("%s.din_strobes", tag), din_en_cnt - db, 2 * ITERS);
        chk($sformatf("%s.din_spacing", tag), viol_cnt - vb, 0);
        chk($sformatf("%s.last_flag", tag), o_flag, 0);
        chk($sformatf("%s.key_out", tag), o_key, key);
        chk($sformatf("%s.timeout", tag), o_timeout, 0);
    endtask

    initial begin
        int cyc, db, nc;
        logic [127:0] rk;
        logic [63:0]  rp;
        clear_corr();
        i_rst = 1'b1; i_start = 1'b0;
        i_kat_key = '0; i_kat_pt = '0; i_kat_ct = '0;
        repeat (5) tick();
        chk("rst.busy", o_busy, 0);
        chk("rst.done", o_done, 0);
        chk("rst.pass", o_pass, 0);
        chk("rst.err", o_err_cnt, 0);
        chk("rst.key_en", o_key_en, 0);
        chk("rst.din_en", o_din_en, 0);
        chk("rst.flag", o_flag, 0);
        chk("rst.key", o_key, 0);
        chk("rst.din", o_din, 0);
        chk("rst.timeout", o_timeout, 0);
        i_rst = 1'b0;
        tick();

        // Clean known-answer run
        run_kat("kat", SPEC_KEY, SPEC_PT, good_ct(SPEC_KEY, SPEC_PT), 1'b0);

        // Wrong CT: 16 mismatches, saturating at 15 with a 4-bit counter
        run_kat("badct", SPEC_KEY, SPEC_PT, good_ct(SPEC_KEY, SPEC_PT) ^ 64'h1, 1'b0);

        // Random vectors with a few corrupted core responses
        for (int r = 0; r < 4; r++) begin
            rk = {$urandom, $urandom, $urandom, $urandom};
            rp = {$urandom, $urandom};
            clear_corr();
            nc = $urandom_range(5, 1);
            for (int j = 0; j < nc; j++) corr[$urandom_range(15, 0)] = {$urandom, $urandom} | 64'h1;
            run_kat($sformatf("rnd%0d", r), rk, rp, good_ct(rk, rp), 1'b0);
        end
        clear_corr();

        // Reset in the middle of a run, with one error already counted
        corr[0] = 64'h80;
        i_kat_key = SPEC_KEY; i_kat_pt = SPEC_PT; i_kat_ct = good_ct(SPEC_KEY, SPEC_PT);
        db = din_en_cnt;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        cyc = 0;
        while ((din_en_cnt - db) < 8 && cyc < 500) begin
            tick();
            cyc++;
        end
        chk("midrst.reached_wdec", din_en_cnt - db, 8);
        chk("midrst.err_before", o_err_cnt, 1);
        i_rst = 1'b1;
        tick();
        chk("midrst.busy", o_busy, 0);
        chk("midrst.done", o_done, 0);
        chk("midrst.din_en", o_din_en, 0);
        chk("midrst.key_en", o_key_en, 0);
        chk("midrst.err", o_err_cnt, 0);
        i_rst = 1'b0;
        clear_corr();
        tick();
        run_kat("after_rst", SPEC_KEY, SPEC_PT, good_ct(SPEC_KEY, SPEC_PT), 1'b0);

        // Stray i_dout_en while waiting for the key, plus start pulse during the run
        stray_en = 1'b1;
        run_kat("stray", SPEC_KEY, SPEC_PT, good_ct(SPEC_KEY, SPEC_PT), 1'b1);
        stray_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
